shift_right_seq_32bit: RTL and testbench
========================================

SHIFT_RIGHT_SEQ_32BIT -- requirements
Module: shift_right_seq_32bit

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and shift amount at 5 bits.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 valid_i  input  1  request valid.
REQ-005 ready_o  output  1  block can accept a request.
REQ-006 data_i  input  32  operand to shift.
REQ-007 shamt_i  input  5  shift amount, 0..31.
REQ-008 arith_i  input  1  1 = arithmetic (SRA, sign fill), 0 = logical (SRL, zero fill).
REQ-009 flush_i  input  1  synchronous abort of any in-flight operation.
REQ-010 valid_o  output  1  result valid.
REQ-011 ready_i  input  1  consumer accepts the result.
REQ-012 data_o  output  32  shifted result.
REQ-013 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 ready_o SHALL be 1 only in IDLE, and combinationally 0 otherwise.
REQ-016 In IDLE, when valid_i=1 and flush_i=0 at a rising edge, the block SHALL latch data_i, shamt_i and arith_i, clear the stage counter to 0, and enter SHIFT.
REQ-017 The stage counter SHALL be 3 bits wide and SHALL count 0..4, one stage per cycle in SHIFT.
REQ-018 At stage k, if the latched shamt bit k is 1, the working register SHALL shift right by 2^k; otherwise it SHALL hold its value.
REQ-019 Vacated MSBs SHALL be filled with the working register bit 31 when arith=1, and with 0 when arith=0.
REQ-020 After stage 4 the FSM SHALL enter DONE; valid_o SHALL be 1 in DONE only.
REQ-021 Latency SHALL be fixed at 5 cycles from the accept edge to valid_o=1 at the 6th edge, independent of shamt, including shamt=0.
REQ-022 In DONE, data_o and valid_o SHALL remain stable until ready_i=1; on the edge with valid_o=1 and ready_i=1 the FSM SHALL return to IDLE.
REQ-023 No new request SHALL be accepted in the same cycle as a result handshake; back-to-back throughput SHALL be one result per 7 cycles minimum.
REQ-024 data_o SHALL be driven by the working register in all states; its value SHALL be meaningful only while valid_o=1.
REQ-025 flush_i=1 at a rising edge in SHIFT or DONE SHALL force IDLE with no result produced; flush_i in IDLE SHALL block acceptance that cycle.
REQ-026 flush_i SHALL take priority over both valid_i and ready_i.
REQ-027 Inputs SHALL be ignored while not in IDLE; changes to data_i/shamt_i/arith_i SHALL NOT affect an in-flight operation.

Reset
REQ-028 rst_ni=0 SHALL immediately, without waiting for a clock, force state=IDLE, stage counter=0, working register=0, latched shamt and arith=0.
REQ-029 During reset: valid_o=0, busy_o=0, data_o=0x0000_0000, and ready_o=1.
REQ-030 Reset asserted mid-SHIFT or mid-DONE SHALL discard the operation; after release the block SHALL accept a new request on the first edge.

Verification
REQ-031 SRL: data_i=0x8000_0000, shamt_i=4, arith_i=0 -> valid_o 5 cycles after accept, data_o=0x0800_0000.
REQ-032 SRA: data_i=0x8000_0000, shamt_i=31, arith_i=1 -> data_o=0xFFFF_FFFF; with arith_i=0 -> data_o=0x0000_0001.
REQ-033 shamt_i=0, data_i=0xDEAD_BEEF -> data_o=0xDEAD_BEEF with unchanged 5-cycle latency.
REQ-034 Backpressure: ready_i=0 for 3 cycles in DONE -> valid_o=1 and data_o stable, ready_o=0, busy_o=1; ready_i=1 -> IDLE on the next edge.
REQ-035 flush_i pulse at stage 2 of shamt_i=7, data_i=0xF000_0000, arith_i=1 -> IDLE next edge, valid_o never asserted, next request accepted normally.
REQ-036 rst_ni low asynchronously mid-SHIFT -> outputs at reset values before the next edge; random SRL/SRA sweep checked against a reference model.

Source files
------------

// File: rtl/shift_right_seq_32bit_if.sv
// Request/result handshake bundle for the sequential 32-bit right shifter.
// The master side drives operands and result acceptance; the slave is the shifter.
interface shift_right_seq_32bit_if;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] data_i;
   logic [4:0]  shamt_i;
   logic        arith_i;
   logic        flush_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] data_o;
   logic        busy_o;

   modport master (
      output valid_i, data_i, shamt_i, arith_i, flush_i, ready_i,
      input  ready_o, valid_o, data_o, busy_o
   );

   modport slave (
      input  valid_i, data_i, shamt_i, arith_i, flush_i, ready_i,
      output ready_o, valid_o, data_o, busy_o
   );
endinterface

// File: rtl/shift_right_seq_32bit.sv
// Sequential SRL/SRA: one log-shifter stage (2^k) per cycle over five cycles,
// result held in DONE until the consumer accepts it.
module shift_right_seq_32bit (
   input logic                    clk_i,
   input logic                    rst_ni,
   shift_right_seq_32bit_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]  state;
   logic [2:0]  stage;
   logic [31:0] work;
   logic [4:0]  shamt;
   logic        arith;

   logic [4:0]  step;
   logic        take;
   logic [31:0] shifted;

   // Stage k contributes a shift of 2^k when shamt bit k is set
   always_comb begin
      step = 5'd0;
      take = 1'b0;
      case (stage)
         3'd0: begin step = 5'd1;  take = shamt[0]; end
         3'd1: begin step = 5'd2;  take = shamt[1]; end
         3'd2: begin step = 5'd4;  take = shamt[2]; end
         3'd3: begin step = 5'd8;  take = shamt[3]; end
         3'd4: begin step = 5'd16; take = shamt[4]; end
         default: begin step = 5'd0; take = 1'b0; end
      endcase
   end

   always_comb begin
      shifted = work;
      if (arith)
         shifted = 32'($signed(work) >>> step);
      else
         shifted = work >> step;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         stage <= 3'd0;
         work  <= 32'd0;
         shamt <= 5'd0;
         arith <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.valid_i && !bus.flush_i) begin
                  work  <= bus.data_i;
                  shamt <= bus.shamt_i;
                  arith <= bus.arith_i;
                  stage <= 3'd0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (bus.flush_i) begin
                  state <= IDLE;
               end else begin
                  if (take)
                     work <= shifted;
                  if (stage == 3'd4)
                     state <= DONE;
                  else
                     stage <= stage + 3'd1;
               end
            end
            DONE: begin
               if (bus.flush_i || bus.ready_i)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ready_o = (state == IDLE);
   assign bus.valid_o = (state == DONE);
   assign bus.busy_o  = (state != IDLE);
   assign bus.data_o  = work;
endmodule

// File: tb/tb_shift_right_seq_32bit.sv
// Directed bench for the sequential right shifter: reset, SRL/SRA,
// latency, backpressure, flush, async reset, throughput and a model sweep.
module tb_shift_right_seq_32bit;
   logic clk;
   logic rst_n;
   int   passed;
   int   total;

   shift_right_seq_32bit_if bus ();

   shift_right_seq_32bit dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Accept one request, scramble the operand inputs, wait for valid_o
   task automatic run_op(input logic [31:0] d, input logic [4:0] s,
                         input logic a, output logic [31:0] res,
                         output int lat, output logic acc);
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.data_i  = d;
      bus.shamt_i = s;
      bus.arith_i = a;
      @(posedge clk);
      #1;
      acc = bus.busy_o & ~bus.ready_o;
      bus.valid_i = 1'b0;
      bus.data_i  = 32'h5A5A_A5A5;
      bus.shamt_i = ~s;
      bus.arith_i = ~a;
      lat = 0;
      while (!bus.valid_o && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = bus.data_o;
   endtask

   task automatic handshake();
      @(negedge clk);
      bus.ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      total++;
      if (bus.valid_o !== 1'b0)
         $display("FAIL reset_valid got %b want 0", bus.valid_o);
      else passed++;
      total++;
      if (bus.busy_o !== 1'b0)
         $display("FAIL reset_busy got %b want 0", bus.busy_o);
      else passed++;
      total++;
      if (bus.data_o !== 32'h0)
         $display("FAIL reset_data got %h want 00000000", bus.data_o);
      else passed++;
      total++;
      if (bus.ready_o !== 1'b1)
         $display("FAIL reset_ready got %b want 1", bus.ready_o);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_srl();
      logic [31:0] r;
      int l;
      logic acc;
      run_op(32'h8000_0000, 5'd4, 1'b0, r, l, acc);
      total++;
      if (l !== 5)
         $display("FAIL srl_latency got %0d want 5", l);
      else passed++;
      total++;
      if (r !== 32'h0800_0000)
         $display("FAIL srl_data got %h want 08000000", r);
      else passed++;
      total++;
      if (bus.ready_o !== 1'b0)
         $display("FAIL srl_ready_done got %b want 0", bus.ready_o);
      else passed++;
      handshake();
      total++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0)
         $display("FAIL srl_return_idle got r%b v%b want r1 v0",
                  bus.ready_o, bus.valid_o);
      else passed++;
   endtask

   task automatic test_sra();
      logic [31:0] r;
      int l;
      logic acc;
      run_op(32'h8000_0000, 5'd31, 1'b1, r, l, acc);
      total++;
      if (r !== 32'hFFFF_FFFF)
         $display("FAIL sra31_data got %h want ffffffff", r);
      else passed++;
      handshake();
      run_op(32'h8000_0000, 5'd31, 1'b0, r, l, acc);
      total++;
      if (r !== 32'h0000_0001)
         $display("FAIL srl31_data got %h want 00000001", r);
      else passed++;
      handshake();
   endtask

   task automatic test_shamt0();
      logic [31:0] r;
      int l;
      logic acc;
      run_op(32'hDEAD_BEEF, 5'd0, 1'b1, r, l, acc);
      total++;
      if (l !== 5)
         $display("FAIL shamt0_latency got %0d want 5", l);
      else passed++;
      total++;
      if (r !== 32'hDEAD_BEEF)
         $display("FAIL shamt0_data got %h want deadbeef", r);
      else passed++;
      handshake();
   endtask

   task automatic test_backpressure();
      logic [31:0] r;
      int l;
      logic acc;
      run_op(32'h1234_5678, 5'd8, 1'b0, r, l, acc);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (bus.valid_o !== 1'b1 || bus.data_o !== 32'h0012_3456 ||
             bus.ready_o !== 1'b0 || bus.busy_o !== 1'b1)
            $display("FAIL bp_hold cyc %0d got v%b d%h r%b b%b want v1 d00123456 r0 b1",
                     i, bus.valid_o, bus.data_o, bus.ready_o, bus.busy_o);
         else passed++;
      end
      handshake();
      total++;
      if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0)
         $display("FAIL bp_release got r%b b%b v%b want r1 b0 v0",
                  bus.ready_o, bus.busy_o, bus.valid_o);
      else passed++;
   endtask

   task automatic test_flush();
      logic [31:0] r;
      int l;
      logic acc;
      logic seen;
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.data_i  = 32'hF000_0000;
      bus.shamt_i = 5'd7;
      bus.arith_i = 1'b1;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.flush_i = 1'b1;
      @(posedge clk);
      #1;
      bus.flush_i = 1'b0;
      total++;
      if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0)
         $display("FAIL flush_idle got r%b b%b want r1 b0",
                  bus.ready_o, bus.busy_o);
      else passed++;
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (bus.valid_o) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0)
         $display("FAIL flush_no_result got valid %b want 0", seen);
      else passed++;
      // flush in IDLE must block acceptance
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.flush_i = 1'b1;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      total++;
      if (bus.ready_o !== 1'b1)
         $display("FAIL flush_idle_block got ready %b want 1", bus.ready_o);
      else passed++;
      run_op(32'hF000_0000, 5'd7, 1'b1, r, l, acc);
      total++;
      if (r !== 32'hFFE0_0000 || l !== 5)
         $display("FAIL flush_next_op got %h lat %0d want ffe00000 lat 5", r, l);
      else passed++;
      handshake();
   endtask

   task automatic test_async_reset();
      logic [31:0] r;
      int l;
      logic acc;
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.data_i  = 32'hABCD_0123;
      bus.shamt_i = 5'd3;
      bus.arith_i = 1'b1;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0 ||
          bus.data_o !== 32'h0 || bus.ready_o !== 1'b1)
         $display("FAIL async_reset got v%b b%b d%h r%b want v0 b0 d00000000 r1",
                  bus.valid_o, bus.busy_o, bus.data_o, bus.ready_o);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'h0000_FF00, 5'd4, 1'b0, r, l, acc);
      total++;
      if (acc !== 1'b1)
         $display("FAIL post_reset_accept got %b want 1", acc);
      else passed++;
      total++;
      if (r !== 32'h0000_0FF0 || l !== 5)
         $display("FAIL post_reset_op got %h lat %0d want 00000ff0 lat 5", r, l);
      else passed++;
      handshake();
   endtask

   task automatic test_back_to_back();
      int first;
      int second;
      logic [31:0] d1;
      first  = -1;
      second = -1;
      d1 = 32'h0;
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.data_i  = 32'h1234_5678;
      bus.shamt_i = 5'd1;
      bus.arith_i = 1'b0;
      bus.ready_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (bus.valid_o) begin
            if (first < 0) begin
               first = c;
               d1 = bus.data_o;
            end else if (second < 0) begin
               second = c;
            end
         end
      end
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      for (int c = 0; c < 20 && !bus.ready_o; c++) begin
         @(posedge clk);
         #1;
      end
      bus.ready_i = 1'b0;
      total++;
      if (first < 0 || second - first !== 7)
         $display("FAIL b2b_period got %0d want 7", second - first);
      else passed++;
      total++;
      if (d1 !== 32'h091A_2B3C)
         $display("FAIL b2b_data got %h want 091a2b3c", d1);
      else passed++;
   endtask

   task automatic test_sweep();
      logic [31:0] d;
      logic [4:0]  s;
      logic        a;
      logic [31:0] r;
      logic [31:0] e;
      int l;
      logic acc;
      for (int i = 0; i < 12; i++) begin
         d = $urandom;
         s = 5'($urandom_range(0, 31));
         a = 1'($urandom_range(0, 1));
         if (i == 0) d[31] = 1'b1;
         e = a ? 32'($signed(d) >>> s) : (d >> s);
         run_op(d, s, a, r, l, acc);
         total++;
         if (r !== e || l !== 5)
            $display("FAIL sweep %0d d%h s%0d a%b got %h lat %0d want %h lat 5",
                     i, d, s, a, r, l, e);
         else passed++;
         handshake();
      end
   endtask

   initial begin
      passed = 0;
      total  = 0;
      bus.valid_i = 1'b0;
      bus.data_i  = 32'h0;
      bus.shamt_i = 5'd0;
      bus.arith_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.ready_i = 1'b0;
      test_reset();
      test_srl();
      test_sra();
      test_shamt0();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_back_to_back();
      test_sweep();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
